// File: rtl/gelato_fetch_scheduler_pkg.sv
// rtl/gelato_fetch_scheduler_pkg.sv - shared sizes, types and helpers for the warp fetch scheduler
`ifndef WARP_NUM
`define WARP_NUM 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SPLIT_TABLE_NUM_WIDTH
`define SPLIT_TABLE_NUM_WIDTH 3
`endif

package gelato_types;
    localparam int WARP_NUM        = `WARP_NUM;
    localparam int ADDR_WIDTH      = `ADDR_WIDTH;
    localparam int SPLIT_NUM_WIDTH = `SPLIT_TABLE_NUM_WIDTH;
    localparam int WARP_NUM_WIDTH  = $clog2(WARP_NUM);

    typedef logic [WARP_NUM_WIDTH-1:0]  warp_num_t;
    typedef logic [ADDR_WIDTH-1:0]      addr_t;
    typedef logic [SPLIT_NUM_WIDTH-1:0] split_num_t;
    typedef logic [WARP_NUM-1:0]        warp_mask_t;

    typedef struct packed {
        warp_num_t  warp;
        addr_t      pc;
        split_num_t split_num;
    } fetch_req_t;

    function automatic warp_mask_t warp_onehot(input warp_num_t w);
        return warp_mask_t'(1) << w;
    endfunction
endpackage

// File: rtl/gelato_fetch_scheduler_if.sv
// rtl/gelato_fetch_scheduler_if.sv - fetch request channel between scheduler and instruction cache
interface gelato_fetch_scheduler_if;
    import gelato_types::*;

    logic       fetch_valid;
    logic       fetch_ready;
    warp_num_t  fetch_warp;
    addr_t      fetch_pc;
    split_num_t fetch_split_num;

    modport master (
        output fetch_valid, fetch_warp, fetch_pc, fetch_split_num,
        input  fetch_ready
    );
    modport slave (
        input  fetch_valid, fetch_warp, fetch_pc, fetch_split_num,
        output fetch_ready
    );
endinterface

// File: rtl/gelato_rr_arbiter.sv
// rtl/gelato_rr_arbiter.sv - combinational round-robin picker: rotate, priority-encode, un-rotate
module gelato_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int IW = $clog2(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  k;

    always_comb begin
        dbl       = {req, req};
        rot       = dbl[ptr +: N];
        gnt_valid = |req;
        k         = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) k = IW'(i);
        end
        // N is a power of two, so the add wraps modulo N for free
        gnt_idx = ptr + k;
    end
endmodule

// File: rtl/gelato_fetch_scheduler.sv
// rtl/gelato_fetch_scheduler.sv - per-core warp fetch scheduler issuing one registered icache request at a time
module gelato_fetch_scheduler
    import gelato_types::*;
(
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     rdy,
    input  logic [WARP_NUM-1:0]                      pc_valid,
    input  logic [WARP_NUM-1:0][ADDR_WIDTH-1:0]      pc,
    input  logic [WARP_NUM-1:0][SPLIT_NUM_WIDTH-1:0] pc_split_num,
    gelato_fetch_scheduler_if.master                 fetch,
    input  logic                                     done_valid,
    input  warp_num_t                                done_warp,
    output logic [WARP_NUM-1:0]                      inflight
);
    fetch_req_t req_q, req_d;
    logic       fetch_valid_q, fetch_valid_d;
    warp_mask_t inflight_q, inflight_d;
    warp_num_t  rr_ptr_q, rr_ptr_d;

    logic       accept;
    logic       load;
    warp_mask_t accept_mask;
    warp_mask_t done_mask;
    warp_mask_t elig;
    logic       gnt_valid;
    warp_num_t  gnt_idx;

    always_comb begin
        accept      = fetch_valid_q & fetch.fetch_ready;
        load        = ~fetch_valid_q | accept;
        accept_mask = accept ? warp_onehot(req_q.warp) : '0;
        done_mask   = done_valid ? warp_onehot(done_warp) : '0;
        // the warp leaving this cycle must not be picked again before inflight catches up
        elig        = pc_valid & ~inflight_q & ~accept_mask;
    end

    gelato_rr_arbiter #(.N(WARP_NUM)) u_arb (
        .req       (elig),
        .ptr       (rr_ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        req_d         = req_q;
        fetch_valid_d = fetch_valid_q;
        inflight_d    = inflight_q;
        rr_ptr_d      = rr_ptr_q;
        if (rdy) begin
            inflight_d = (inflight_q & ~done_mask) | accept_mask;
            if (load) begin
                fetch_valid_d = gnt_valid;
                if (gnt_valid) begin
                    req_d.warp      = gnt_idx;
                    req_d.pc        = pc[gnt_idx];
                    req_d.split_num = pc_split_num[gnt_idx];
                    rr_ptr_d        = gnt_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q         <= '0;
            fetch_valid_q <= 1'b0;
            inflight_q    <= '0;
            rr_ptr_q      <= '0;
        end else begin
            req_q         <= req_d;
            fetch_valid_q <= fetch_valid_d;
            inflight_q    <= inflight_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign fetch.fetch_valid     = fetch_valid_q;
    assign fetch.fetch_warp      = req_q.warp;
    assign fetch.fetch_pc        = req_q.pc;
    assign fetch.fetch_split_num = req_q.split_num;
    assign inflight              = inflight_q;
endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
// tb/tb_gelato_fetch_scheduler.sv - directed table-driven bench for gelato_fetch_scheduler
module tb_gelato_fetch_scheduler;
    import gelato_types::*;

    logic                                     clk = 1'b0;
    logic                                     rst_n;
    logic                                     rdy;
    logic [WARP_NUM-1:0]                      pc_valid;
    logic [WARP_NUM-1:0][ADDR_WIDTH-1:0]      pc;
    logic [WARP_NUM-1:0][SPLIT_NUM_WIDTH-1:0] pc_split_num;
    logic                                     done_valid;
    warp_num_t                                done_warp;
    logic [WARP_NUM-1:0]                      inflight;

    int checks = 0;
    int errors = 0;

    gelato_fetch_scheduler_if fif ();

    gelato_fetch_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rdy          (rdy),
        .pc_valid     (pc_valid),
        .pc           (pc),
        .pc_split_num (pc_split_num),
        .fetch        (fif.master),
        .done_valid   (done_valid),
        .done_warp    (done_warp),
        .inflight     (inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       rdy;
        logic [3:0] pc_valid;
        logic       ready;
        logic       done_v;
        logic [1:0] done_w;
        logic       exp_valid;
        logic       chk_data;
        logic [1:0] exp_warp;
        logic [3:0] exp_inflight;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic [3:0] pv, input logic fr,
                       input logic dv, input logic [1:0] dw, input logic ev, input logic cd,
                       input logic [1:0] ew, input logic [3:0] ei);
        vec_t v;
        v.rst_n = r; v.rdy = e; v.pc_valid = pv; v.ready = fr; v.done_v = dv; v.done_w = dw;
        v.exp_valid = ev; v.chk_data = cd; v.exp_warp = ew; v.exp_inflight = ei;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] pv, input logic fr,
                        input logic dv, input logic [1:0] dw);
        rst_n = r; rdy = e; pc_valid = pv; fif.fetch_ready = fr; done_valid = dv; done_warp = dw;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic cd,
                           input logic [1:0] ew, input logic [31:0] epc,
                           input logic [2:0] esp, input logic [3:0] ei);
        chk({tag, " valid"}, 32'(fif.fetch_valid), 32'(ev));
        chk({tag, " inflight"}, 32'(inflight), 32'(ei));
        if (cd) begin
            chk({tag, " warp"}, 32'(fif.fetch_warp), 32'(ew));
            chk({tag, " pc"}, fif.fetch_pc, epc);
            chk({tag, " split"}, 32'(fif.fetch_split_num), 32'(esp));
        end
    endtask

    function automatic logic [31:0] base_pc(input logic [1:0] w);
        return 32'h1000 + 32'(w) * 32'h10;
    endfunction

    initial begin
        for (int i = 0; i < WARP_NUM; i++) begin
            pc[i]           = base_pc(2'(i));
            pc_split_num[i] = 3'(i + 1);
        end
        rst_n = 1'b0; rdy = 1'b0; pc_valid = '0; fif.fetch_ready = 1'b0;
        done_valid = 1'b0; done_warp = '0;

        //   rst rdy pv      fr dv dw  ev cd ew  inflight
        add(0, 0, 4'h0,    0, 0, 0,  0, 1, 0, 4'b0000);
        add(1, 1, 4'hF,    1, 0, 0,  1, 1, 0, 4'b0000);
        add(1, 1, 4'hF,    1, 0, 0,  1, 1, 1, 4'b0001);
        add(1, 1, 4'hF,    1, 0, 0,  1, 1, 2, 4'b0011);
        add(1, 1, 4'hF,    1, 0, 0,  1, 1, 3, 4'b0111);
        add(1, 1, 4'hF,    1, 0, 0,  0, 0, 0, 4'b1111);
        add(1, 1, 4'hF,    1, 0, 0,  0, 0, 0, 4'b1111);
        add(1, 1, 4'hF,    1, 1, 1,  0, 0, 0, 4'b1101);
        add(1, 1, 4'hF,    1, 0, 0,  1, 1, 1, 4'b1101);
        add(1, 1, 4'hF,    1, 1, 1,  0, 0, 0, 4'b1111);
        add(1, 1, 4'hF,    1, 1, 0,  0, 0, 0, 4'b1110);
        add(1, 1, 4'hF,    0, 1, 0,  1, 1, 0, 4'b1110);
        for (int i = 0; i < 5; i++)
            add(1, 0, 4'hF, 1, 0, 0,  1, 1, 0, 4'b1110);
        add(1, 1, 4'hF,    0, 0, 0,  1, 1, 0, 4'b1110);
        add(0, 0, 4'hF,    1, 0, 0,  0, 1, 0, 4'b0000);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].rdy, vecs[i].pc_valid, vecs[i].ready,
                 vecs[i].done_v, vecs[i].done_w);
            chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].chk_data,
                    vecs[i].exp_warp,
                    vecs[i].rst_n ? base_pc(vecs[i].exp_warp) : 32'h0,
                    vecs[i].rst_n ? 3'(vecs[i].exp_warp + 1) : 3'h0,
                    vecs[i].exp_inflight);
        end

        // stall holds the captured request even though pc[2] moves underneath it
        pc[2] = 32'h100;
        step(1, 1, 4'b0100, 0, 0, 0);
        chk_out("stall_load", 1, 1, 2, 32'h100, 3, 4'b0000);
        pc[2] = 32'h200;
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 4'b0100, 0, 0, 0);
            chk_out($sformatf("stall%0d", i), 1, 1, 2, 32'h100, 3, 4'b0000);
        end
        step(1, 1, 4'b0100, 1, 0, 0);
        chk_out("stall_accept", 0, 0, 0, 0, 0, 4'b0100);
        step(1, 1, 4'b0100, 1, 1, 2);
        chk_out("stall_done", 0, 0, 0, 0, 0, 4'b0000);
        step(1, 1, 4'b0100, 0, 0, 0);
        chk_out("new_pc", 1, 1, 2, 32'h200, 3, 4'b0000);
        step(1, 1, 4'b0100, 1, 0, 0);
        chk_out("new_pc_acc", 0, 0, 0, 0, 0, 4'b0100);

        // rr_ptr is now 3: warp 3 beats warp 0, then wrap to warp 0
        pc[2] = base_pc(2);
        step(1, 1, 4'b1001, 1, 1, 2);
        chk_out("wrap_a", 1, 1, 3, base_pc(3), 4, 4'b0000);
        step(1, 1, 4'b1001, 1, 0, 0);
        chk_out("wrap_b", 1, 1, 0, base_pc(0), 1, 4'b1000);
        step(1, 1, 4'b1001, 1, 0, 0);
        chk_out("wrap_c", 0, 0, 0, 0, 0, 4'b1001);
        step(1, 1, 4'b0000, 0, 1, 0);
        chk_out("wrap_d", 0, 0, 0, 0, 0, 4'b1000);
        // warps 0 and 1 both eligible: rr_ptr==1 must pick warp 1
        step(1, 1, 4'b0011, 0, 0, 0);
        chk_out("rr_ptr1", 1, 1, 1, base_pc(1), 2, 4'b1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
